seg7_digit_sequencer: RTL and testbench

//  Time-multiplexed single-display digit sequencer. Captures NDIGITS packed nibbles on a load

---
 rtl/seg7_pkg.sv | 13 +
 rtl/seg7_encoder.sv | 17 +
 rtl/seg7_digit_sequencer.sv | 80 ++++++++
 tb/tb_seg7_digit_sequencer.sv | 107 ++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared mode/state types, segment constants and hex glyph table
package seg7_pkg;
   typedef enum logic [1:0] {HEX, DEC, BLINK, BLANK} mode_e;
   typedef enum logic {IDLE, SHOW} state_e;
   localparam logic [7:0] SEG_BLANK = 8'h00;
   localparam logic [7:0] SEG_ERR   = 8'hF9;
   localparam logic [7:0] SEG_DP    = 8'h80;
   localparam logic [7:0] GLYPH [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                          8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
   function automatic logic [7:0] hex_to_seg(input logic [3:0] n);
      return GLYPH[n];
   endfunction
endpackage

// File: rtl/seg7_encoder.sv
// seg7_encoder: combinational nibble-to-segment pattern for the selected display mode
module seg7_encoder
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   input  mode_e      mode,
   input  logic       blink_on,
   input  logic       is_last,
   output logic [7:0] seg
);
   logic [7:0] glyph;
   assign glyph = hex_to_seg(nibble) | (is_last ? SEG_DP : SEG_BLANK);
   always_comb
      seg = mode == HEX   ? glyph :
            mode == DEC   ? (nibble > 4'd9 ? SEG_ERR : glyph) :
            mode == BLINK ? (blink_on ? glyph : SEG_BLANK) : SEG_BLANK;
endmodule

// File: rtl/seg7_digit_sequencer.sv
// seg7_digit_sequencer: shows captured nibbles one at a time on a single 7-segment display
// Outputs are registered from next-state values so SEG always tracks digit_idx on the same edge.
module seg7_digit_sequencer
   import seg7_pkg::*;
#(
   parameter int NDIGITS = 4,
   parameter int DWELL   = 8,
   parameter int IDX_W   = $clog2(NDIGITS)
) (
   input  logic                   clk_2,
   input  logic                   reset_n,
   input  logic                   load,
   input  logic [4*NDIGITS-1:0]   digits_in,
   input  logic [1:0]             mode,
   input  logic                   repeat_en,
   output logic [7:0]             SEG,
   output logic [IDX_W-1:0]       digit_idx,
   output logic                   busy,
   output logic                   done
);
   localparam int DW_W = $clog2(DWELL);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NDIGITS - 1);
   localparam logic [DW_W-1:0]  DMAX = DW_W'(DWELL - 1);
   state_e               state, state_n;
   mode_e                mode_q, mode_n;
   logic [DW_W-1:0]      dwell, dwell_n;
   logic [IDX_W-1:0]     idx_n;
   logic [4*NDIGITS-1:0] data, data_n;
   logic [7:0]           glyph;
   always_comb begin
      state_n = state;
      mode_n  = mode_q;
      dwell_n = dwell;
      idx_n   = digit_idx;
      data_n  = data;
      if (state == IDLE) begin
         if (load) begin
            state_n = SHOW;
            mode_n  = mode_e'(mode);
            dwell_n = '0;
            idx_n   = '0;
            data_n  = digits_in;
         end
      end else if (dwell != DMAX) dwell_n = dwell + 1'b1;
      else begin
         dwell_n = '0;
         idx_n   = digit_idx == LAST ? '0 : digit_idx + 1'b1;
         if (digit_idx == LAST && !repeat_en) state_n = IDLE;
      end
   end
   // encode what will be shown next cycle, so the glyph is never one digit behind
   seg7_encoder u_enc (
      .nibble   (data_n[{idx_n, 2'b00} +: 4]),
      .mode     (mode_n),
      .blink_on (dwell_n < DW_W'(DWELL / 2)),
      .is_last  (idx_n == LAST),
      .seg      (glyph)
   );
   always_ff @(posedge clk_2) begin
      if (!reset_n) begin
         state     <= IDLE;
         mode_q    <= HEX;
         dwell     <= '0;
         digit_idx <= '0;
         data      <= '0;
         SEG       <= SEG_BLANK;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         mode_q    <= mode_n;
         dwell     <= dwell_n;
         digit_idx <= idx_n;
         data      <= data_n;
         SEG       <= state_n == SHOW ? glyph : SEG_BLANK;
         busy      <= state_n == SHOW;
         done      <= state_n == SHOW && idx_n == LAST && dwell_n == DMAX;
      end
   end
endmodule

// File: tb/tb_seg7_digit_sequencer.sv
// tb_seg7_digit_sequencer: scoreboard bench with hand-computed glyph sequences per test
module tb_seg7_digit_sequencer;
   typedef struct packed {
      logic [7:0] seg;
      logic [1:0] idx;
      logic       busy;
      logic       done;
   } exp_t;
   logic        clk_2 = 1'b0;
   logic        reset_n, load, repeat_en;
   logic [15:0] digits_in;
   logic [1:0]  mode;
   logic [7:0]  SEG;
   logic [1:0]  digit_idx;
   logic        busy, done;
   exp_t        q[$];
   exp_t        act, exp_v;
   logic        mon_en = 1'b0;
   int          checks = 0;
   int          fails = 0;
   seg7_digit_sequencer #(.NDIGITS(4), .DWELL(8)) dut (
      .clk_2(clk_2), .reset_n(reset_n), .load(load), .digits_in(digits_in), .mode(mode),
      .repeat_en(repeat_en), .SEG(SEG), .digit_idx(digit_idx), .busy(busy), .done(done)
   );
   always #5 clk_2 = ~clk_2;
   // monitor: each cycle pops the expected output, or expects idle when nothing is queued
   always @(negedge clk_2) begin
      if (mon_en) begin
         act   = '{SEG, digit_idx, busy, done};
         exp_v = q.size() != 0 ? q.pop_front() : exp_t'(0);
         checks++;
         if (act !== exp_v) begin
            fails++;
            $display("FAIL out @%0t: got seg=%h idx=%0d busy=%b done=%b, want seg=%h idx=%0d busy=%b done=%b",
                     $time, act.seg, act.idx, act.busy, act.done,
                     exp_v.seg, exp_v.idx, exp_v.busy, exp_v.done);
         end
      end
   end
   task automatic start(input logic [15:0] d, input logic [1:0] m);
      @(posedge clk_2);
      #1 digits_in = d; mode = m; load = 1'b1;
      @(posedge clk_2);
      #1 load = 1'b0;
   endtask
   task automatic push_pass(input logic [7:0] g0, g1, g2, g3, input bit blink, input bit fin);
      logic [7:0] g [4];
      g = '{g0, g1, g2, g3};
      for (int k = 0; k < 4; k++)
         for (int d = 0; d < 8; d++)
            q.push_back('{(blink && d >= 4) ? 8'h00 : g[k], 2'(k), 1'b1, k == 3 && d == 7});
      if (fin) q.push_back(exp_t'(0));
   endtask
   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         @(posedge clk_2);
         n++;
      end
      if (q.size() != 0) begin
         checks++;
         fails++;
         $display("FAIL drain: %0d entries left, want 0", q.size());
         q.delete();
      end
      repeat (2) @(posedge clk_2);
   endtask
   initial begin
      reset_n = 1'b0; load = 1'b1; repeat_en = 1'b1; digits_in = 16'hABCD; mode = 2'b10;
      repeat (2) @(posedge clk_2);
      #1 load = 1'b0; repeat_en = 1'b0; reset_n = 1'b1; mon_en = 1'b1;
      repeat (2) @(posedge clk_2);
      start(16'h4321, 2'b00);
      push_pass(8'h06, 8'h5B, 8'h4F, 8'hE6, 0, 1);
      drain();
      start(16'hF0A9, 2'b01);
      push_pass(8'h6F, 8'hF9, 8'h3F, 8'hF9, 0, 1);
      drain();
      start(16'h8888, 2'b10);
      push_pass(8'h7F, 8'h7F, 8'h7F, 8'hFF, 1, 1);
      drain();
      repeat_en = 1'b1;
      start(16'h4321, 2'b00);
      push_pass(8'h06, 8'h5B, 8'h4F, 8'hE6, 0, 0);
      repeat (16) @(posedge clk_2);
      #1 load = 1'b1; digits_in = 16'hFFFF; mode = 2'b11;
      @(posedge clk_2);
      #1 load = 1'b0;
      push_pass(8'h06, 8'h5B, 8'h4F, 8'hE6, 0, 1);
      repeat (16) @(posedge clk_2);
      #1 repeat_en = 1'b0;
      drain();
      start(16'h4321, 2'b00);
      push_pass(8'h06, 8'h5B, 8'h4F, 8'hE6, 0, 1);
      repeat (9) @(posedge clk_2);
      #1 reset_n = 1'b0;
      @(posedge clk_2);
      #1 q.delete(); reset_n = 1'b1;
      repeat (3) @(posedge clk_2);
      start(16'h1234, 2'b11);
      push_pass(8'h00, 8'h00, 8'h00, 8'h00, 0, 1);
      drain();
      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
